// File: rtl/bomb_scheduler.sv
// Two-player bomb slot scheduler: request arbitration, fuse/blast timing and a
// single shared bomb-map write port with round-robin arbitration.
//
// state | meaning
// IDLE  | slot empty; drop requests are evaluated
// ARMED | bomb placed; fuse down-counter steps on tick
// BLAST | bomb exploding; blast down-counter steps on tick
module bomb_scheduler #(
  parameter int GRID        = 10,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       reqA,
  input  logic [3:0] reqA_x,
  input  logic [3:0] reqA_y,
  input  logic       reqB,
  input  logic [3:0] reqB_x,
  input  logic [3:0] reqB_y,
  output logic       grantA,
  output logic       grantB,
  output logic       rejectA,
  output logic       rejectB,
  output logic       bombA_v,
  output logic [3:0] bombA_x,
  output logic [3:0] bombA_y,
  output logic       bombB_v,
  output logic [3:0] bombB_x,
  output logic [3:0] bombB_y,
  output logic       blastA,
  output logic       blastB,
  output logic       wr_en,
  output logic [3:0] wr_x,
  output logic [3:0] wr_y,
  output logic [1:0] wr_code
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BLAST = 2'd2} state_t;

  localparam logic [4:0] GRID_L   = 5'(GRID);
  localparam logic [3:0] FUSE_LD  = (FUSE_TICKS == 0) ? 4'd1 : 4'(FUSE_TICKS);
  localparam logic [3:0] BLAST_LD = (BLAST_TICKS == 0) ? 4'd1 : 4'(BLAST_TICKS);

  state_t     st_a, st_b;
  logic [3:0] cnt_a, cnt_b;
  logic [3:0] xa, ya, xb, yb;
  logic       pend_a, pend_b;
  logic       rr_b;  // 0: A has priority, 1: B has priority

  logic legal_a, legal_b, conflict, acc_a, acc_b, rej_a, rej_b;
  logic ev_a, ev_b, serve_a, serve_b, contend;

  function automatic logic [1:0] code_of(state_t s);
    case (s)
      ARMED:   code_of = 2'b01;
      BLAST:   code_of = 2'b10;
      default: code_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    legal_a  = reqA && (st_a == IDLE) && ({1'b0, reqA_x} < GRID_L) && ({1'b0, reqA_y} < GRID_L)
               && !((st_b != IDLE) && (reqA_x == xb) && (reqA_y == yb));
    legal_b  = reqB && (st_b == IDLE) && ({1'b0, reqB_x} < GRID_L) && ({1'b0, reqB_y} < GRID_L)
               && !((st_a != IDLE) && (reqB_x == xa) && (reqB_y == ya));
    conflict = legal_a && legal_b && (reqA_x == reqB_x) && (reqA_y == reqB_y);
    acc_a    = legal_a && !(conflict && rr_b);
    acc_b    = legal_b && !(conflict && !rr_b);
    rej_a    = reqA && (st_a == IDLE) && !acc_a;
    rej_b    = reqB && (st_b == IDLE) && !acc_b;
    // terminal-count events that change what the map should show
    ev_a     = tick && (st_a != IDLE) && (cnt_a == 4'd1);
    ev_b     = tick && (st_b != IDLE) && (cnt_b == 4'd1);
    contend  = pend_a && pend_b;
    serve_a  = pend_a && (!pend_b || !rr_b);
    serve_b  = pend_b && (!pend_a || rr_b);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_a    <= IDLE;
      st_b    <= IDLE;
      cnt_a   <= 4'd0;
      cnt_b   <= 4'd0;
      xa      <= 4'd0;
      ya      <= 4'd0;
      xb      <= 4'd0;
      yb      <= 4'd0;
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      rr_b    <= 1'b0;
      grantA  <= 1'b0;
      grantB  <= 1'b0;
      rejectA <= 1'b0;
      rejectB <= 1'b0;
      wr_en   <= 1'b0;
      wr_x    <= 4'd0;
      wr_y    <= 4'd0;
      wr_code <= 2'b00;
    end else begin
      grantA  <= acc_a;
      grantB  <= acc_b;
      rejectA <= rej_a;
      rejectB <= rej_b;

      case (st_a)
        IDLE: if (acc_a) begin
          st_a  <= ARMED;
          cnt_a <= FUSE_LD;
          xa    <= reqA_x;
          ya    <= reqA_y;
        end
        ARMED: if (tick) begin
          if (cnt_a == 4'd1) begin
            st_a  <= BLAST;
            cnt_a <= BLAST_LD;
          end else cnt_a <= cnt_a - 4'd1;
        end
        BLAST: if (tick) begin
          if (cnt_a == 4'd1) st_a <= IDLE;
          cnt_a <= cnt_a - 4'd1;
        end
        default: st_a <= IDLE;
      endcase

      case (st_b)
        IDLE: if (acc_b) begin
          st_b  <= ARMED;
          cnt_b <= FUSE_LD;
          xb    <= reqB_x;
          yb    <= reqB_y;
        end
        ARMED: if (tick) begin
          if (cnt_b == 4'd1) begin
            st_b  <= BLAST;
            cnt_b <= BLAST_LD;
          end else cnt_b <= cnt_b - 4'd1;
        end
        BLAST: if (tick) begin
          if (cnt_b == 4'd1) st_b <= IDLE;
          cnt_b <= cnt_b - 4'd1;
        end
        default: st_b <= IDLE;
      endcase

      // a new event coinciding with issue re-arms pending so it is not lost
      pend_a <= acc_a || ev_a || (pend_a && !serve_a);
      pend_b <= acc_b || ev_b || (pend_b && !serve_b);

      wr_en <= serve_a || serve_b;
      if (serve_a) begin
        wr_x    <= xa;
        wr_y    <= ya;
        wr_code <= code_of(st_a);
      end else if (serve_b) begin
        wr_x    <= xb;
        wr_y    <= yb;
        wr_code <= code_of(st_b);
      end

      if (conflict || contend) rr_b <= !rr_b;
    end
  end

  assign bombA_v = (st_a != IDLE);
  assign bombB_v = (st_b != IDLE);
  assign blastA  = (st_a == BLAST);
  assign blastB  = (st_b == BLAST);
  assign bombA_x = xa;
  assign bombA_y = ya;
  assign bombB_x = xb;
  assign bombB_y = yb;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: grant/reject rules, fuse and blast timing,
// shared write-port ordering and reset abort behaviour.
module tb_bomb_scheduler;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic       reqA, reqB;
  logic [3:0] reqA_x, reqA_y, reqB_x, reqB_y;
  logic       grantA, grantB, rejectA, rejectB;
  logic       bombA_v, bombB_v, blastA, blastB;
  logic [3:0] bombA_x, bombA_y, bombB_x, bombB_y;
  logic       wr_en;
  logic [3:0] wr_x, wr_y;
  logic [1:0] wr_code;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int grant_a_cnt = 0;
  int reject_a_cnt = 0;

  always #5 clk = ~clk;

  bomb_scheduler #(.GRID(10), .FUSE_TICKS(3), .BLAST_TICKS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .reqA(reqA), .reqA_x(reqA_x), .reqA_y(reqA_y),
    .reqB(reqB), .reqB_x(reqB_x), .reqB_y(reqB_y),
    .grantA(grantA), .grantB(grantB), .rejectA(rejectA), .rejectB(rejectB),
    .bombA_v(bombA_v), .bombA_x(bombA_x), .bombA_y(bombA_y),
    .bombB_v(bombB_v), .bombB_x(bombB_x), .bombB_y(bombB_y),
    .blastA(blastA), .blastB(blastB),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_code(wr_code)
  );

  logic [34:0] all_outs;
  assign all_outs = {grantA, grantB, rejectA, rejectB, bombA_v, bombB_v, blastA, blastB,
                     wr_en, wr_code, bombA_x, bombA_y, bombB_x, bombB_y, wr_x, wr_y};

  always @(negedge clk) begin
    if (wr_en) wr_count++;
    if (grantA) grant_a_cnt++;
    if (rejectA) reject_a_cnt++;
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_once;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0; tick = 1'b0; reqA = 1'b0; reqB = 1'b0;
    step(2);
    rst = 1'b1;
    step();
  endtask

  task automatic drive_a(input logic v, input logic [3:0] x, input logic [3:0] y);
    reqA = v; reqA_x = x; reqA_y = y;
  endtask

  task automatic drive_b(input logic v, input logic [3:0] x, input logic [3:0] y);
    reqB = v; reqB_x = x; reqB_y = y;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int wc0, ga0, ra0;
    rst = 1'b0; tick = 1'b0;
    drive_a(1'b0, 4'd0, 4'd0);
    drive_b(1'b0, 4'd0, 4'd0);
    step(2);
    chk_val("reset_outputs", 64'(all_outs), 64'd0);
    rst = 1'b1;
    step();

    // single bomb lifecycle at (2,3)
    wc0 = wr_count;
    drive_a(1'b1, 4'd2, 4'd3);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    chk_val("t1_grant", {grantA, rejectA, bombA_v, bombA_x, bombA_y}, {1'b1, 1'b0, 1'b1, 4'd2, 4'd3});
    chk_val("t1_no_wr_n1", 64'(wr_en), 64'd0);
    step();
    chk_val("t1_wr_armed", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd2, 4'd3, 2'b01});
    step(8);
    tick_once; step(9);
    tick_once; step(9);
    chk_val("t1_not_blast_2ticks", {bombA_v, blastA}, {1'b1, 1'b0});
    tick_once;
    chk_val("t1_blast", {bombA_v, blastA, wr_en}, {1'b1, 1'b1, 1'b0});
    step();
    chk_val("t1_wr_blast", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd2, 4'd3, 2'b10});
    step(8);
    tick_once;
    chk_val("t1_idle", {bombA_v, blastA}, {1'b0, 1'b0});
    step();
    chk_val("t1_wr_clear", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd2, 4'd3, 2'b00});
    step(2);
    chk_val("t1_wr_count", 64'(wr_count - wc0), 64'd3);

    // same-cell conflict, A wins after reset, B wins the repeat
    do_reset;
    drive_a(1'b1, 4'd5, 4'd5);
    drive_b(1'b1, 4'd5, 4'd5);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    drive_b(1'b0, 4'd0, 4'd0);
    chk_val("t2_first", {grantA, rejectA, grantB, rejectB}, 4'b1001);
    wc0 = wr_count;
    step();
    chk_val("t2_wr", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd5, 4'd5, 2'b01});
    step(3);
    chk_val("t2_one_write", 64'(wr_count - wc0), 64'd1);
    tick_once; step(3);
    tick_once; step(3);
    tick_once; step(3);
    tick_once; step(3);
    chk_val("t2_a_cleared", {bombA_v, bombB_v}, 2'b00);
    drive_a(1'b1, 4'd5, 4'd5);
    drive_b(1'b1, 4'd5, 4'd5);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    drive_b(1'b0, 4'd0, 4'd0);
    chk_val("t2_repeat", {grantA, rejectA, grantB, rejectB}, 4'b0110);

    // different cells, both granted, writes serialised A then B
    do_reset;
    drive_a(1'b1, 4'd1, 4'd1);
    drive_b(1'b1, 4'd8, 4'd8);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    drive_b(1'b0, 4'd0, 4'd0);
    chk_val("t3_grants", {grantA, grantB, rejectA, rejectB}, 4'b1100);
    step();
    chk_val("t3_wr_a", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd1, 4'd1, 2'b01});
    step();
    chk_val("t3_wr_b", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd8, 4'd8, 2'b01});
    step();
    chk_val("t3_wr_done", 64'(wr_en), 64'd0);

    // out-of-range and occupied-cell refusals, top legal coordinate
    do_reset;
    wc0 = wr_count;
    drive_b(1'b1, 4'd10, 4'd4);
    step();
    drive_b(1'b0, 4'd0, 4'd0);
    chk_val("t4_range_reject", {grantB, rejectB, bombB_v}, 3'b010);
    step(3);
    chk_val("t4_no_write", 64'(wr_count - wc0), 64'd0);
    drive_a(1'b1, 4'd3, 4'd3);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    chk_val("t4_a_grant", 64'(grantA), 64'd1);
    step(2);
    drive_b(1'b1, 4'd3, 4'd3);
    step();
    drive_b(1'b0, 4'd0, 4'd0);
    chk_val("t4_occupied_reject", {grantB, rejectB, bombB_v}, 3'b010);
    drive_b(1'b1, 4'd9, 4'd9);
    step();
    drive_b(1'b0, 4'd0, 4'd0);
    chk_val("t4_edge_grant", {grantB, rejectB, bombB_v, bombB_x, bombB_y}, {3'b101, 4'd9, 4'd9});

    // request held through ARMED: exactly one grant, no reject
    do_reset;
    ga0 = grant_a_cnt;
    ra0 = reject_a_cnt;
    drive_a(1'b1, 4'd4, 4'd4);
    step(3);
    tick_once; step(3);
    tick_once; step(3);
    tick_once;
    chk_val("t5_in_blast", 64'(blastA), 64'd1);
    drive_a(1'b0, 4'd0, 4'd0);
    step();
    chk_val("t5_grants", 64'(grant_a_cnt - ga0), 64'd1);
    chk_val("t5_rejects", 64'(reject_a_cnt - ra0), 64'd0);

    // reset during BLAST with a write pending aborts without a write
    do_reset;
    drive_a(1'b1, 4'd6, 4'd7);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    step(3);
    tick_once; step(3);
    tick_once; step(3);
    tick_once;
    chk_val("t6_blast", {blastA, wr_en}, 2'b10);
    wc0 = wr_count;
    rst = 1'b0;
    step();
    chk_val("t6_reset_outs", 64'(all_outs), 64'd0);
    step();
    rst = 1'b1;
    step(2);
    chk_val("t6_no_write", 64'(wr_count - wc0), 64'd0);
    drive_a(1'b1, 4'd6, 4'd7);
    step();
    drive_a(1'b0, 4'd0, 4'd0);
    chk_val("t6_regrant", {grantA, rejectA, bombA_v}, 3'b101);
    step();
    chk_val("t6_wr", {wr_en, wr_x, wr_y, wr_code}, {1'b1, 4'd6, 4'd7, 2'b01});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
